// File: rtl/ysyx_22050612_ifu.sv
// Instruction fetch unit: holds the PC, issues one fetch at a time over a
// valid/ready memory channel and presents {pc, inst, fault} to the decoder.
module ysyx_22050612_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_rsp_valid,
  output logic        mem_rsp_ready,
  input  logic [31:0] mem_rsp_data,
  input  logic        mem_rsp_err,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic        out_fault,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] fetch_count
);

  typedef enum logic [2:0] {StBoot, StReq, StWait, StDrop, StHold} state_e;

  state_e      r_state, w_state_d;
  logic [31:0] r_pc, w_pc_d;
  logic [31:0] r_inst, w_inst_d;
  logic        r_fault, w_fault_d;
  logic [31:0] r_count, w_count_d;

  always_comb begin
    w_state_d = r_state;
    w_pc_d    = r_pc;
    w_inst_d  = r_inst;
    w_fault_d = r_fault;
    w_count_d = r_count;
    unique case (r_state)
      StBoot: w_state_d = StReq;
      StReq: begin
        if (redirect_valid) begin
          w_pc_d    = redirect_pc;
          w_state_d = mem_req_ready ? StDrop : StReq;
        end else if (mem_req_ready) begin
          w_state_d = StWait;
        end
      end
      StWait: begin
        if (redirect_valid) begin
          w_pc_d    = redirect_pc;
          w_state_d = mem_rsp_valid ? StReq : StDrop;
        end else if (mem_rsp_valid) begin
          w_inst_d  = mem_rsp_data;
          w_fault_d = mem_rsp_err;
          w_state_d = StHold;
        end
      end
      StDrop: begin
        if (redirect_valid) w_pc_d = redirect_pc;
        if (mem_rsp_valid) w_state_d = StReq;
      end
      StHold: begin
        if (out_ready) w_count_d = r_count + 32'd1;
        if (redirect_valid) begin
          w_pc_d    = redirect_pc;
          w_state_d = StReq;
        end else if (out_ready) begin
          w_pc_d    = r_pc + 32'd4;
          w_state_d = StReq;
        end
      end
      default: w_state_d = StBoot;
    endcase
    // A misaligned pc never reaches memory: report the fault instead of requesting.
    if (w_state_d == StReq && w_pc_d[1:0] != 2'b00) begin
      w_state_d = StHold;
      w_inst_d  = 32'h0;
      w_fault_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StBoot;
      r_pc    <= RESET_PC;
      r_inst  <= 32'h0;
      r_fault <= 1'b0;
      r_count <= 32'h0;
    end else begin
      r_state <= w_state_d;
      r_pc    <= w_pc_d;
      r_inst  <= w_inst_d;
      r_fault <= w_fault_d;
      r_count <= w_count_d;
    end
  end

  assign mem_req_valid = (r_state == StReq);
  assign mem_req_addr  = r_pc;
  assign mem_rsp_ready = (r_state == StWait) || (r_state == StDrop);
  assign out_valid     = (r_state == StHold);
  assign out_pc        = r_pc;
  assign out_inst      = r_inst;
  assign out_fault     = r_fault;
  assign fetch_count   = r_count;

endmodule

// File: tb/tb_ysyx_22050612_ifu.sv
// Bench for the fetch unit: memory model, directed stimulus, and a scoreboard
// monitor that checks every instruction handed to the decoder.
module tb_ysyx_22050612_ifu;

  logic        clk;
  logic        rst;
  logic        mem_req_valid, mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid, mem_rsp_ready;
  logic [31:0] mem_rsp_data;
  logic        mem_rsp_err;
  logic        out_valid, out_ready;
  logic [31:0] out_pc, out_inst;
  logic        out_fault;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] fetch_count;

  ysyx_22050612_ifu dut (
    .clk            (clk),
    .rst            (rst),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_ready  (mem_rsp_ready),
    .mem_rsp_data   (mem_rsp_data),
    .mem_rsp_err    (mem_rsp_err),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_inst       (out_inst),
    .out_fault      (out_fault),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_count    (fetch_count)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        fault;
  } exp_t;

  exp_t        sb[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          rsp_delay = 0;
  logic [31:0] err_addr = 32'hffff_ffff;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(logic [31:0] pc, logic [31:0] inst, logic fault);
    exp_t e;
    e.pc = pc;
    e.inst = inst;
    e.fault = fault;
    sb.push_back(e);
  endtask

  task automatic wait_out(string name);
    int n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    if (!out_valid) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: out_valid timeout got 0 expected 1", name);
    end
  endtask

  task automatic wait_req(string name, logic [31:0] addr);
    int n = 0;
    while (!mem_req_valid && n < 20) begin
      tick();
      n++;
    end
    chk({name, "_req_valid"}, {31'd0, mem_req_valid}, 32'd1);
    chk({name, "_req_addr"}, mem_req_addr, addr);
  endtask

  // Issue with out_ready high until the instruction is handed over.
  task automatic do_fetch(string name, logic [31:0] pc, logic [31:0] inst, logic fault);
    expect_out(pc, inst, fault);
    out_ready = 1'b1;
    wait_out(name);
    tick();
    out_ready = 1'b0;
  endtask

  // Memory: one outstanding request; data = {addr[15:0], 16'h0013}.
  initial begin
    bit          req_hs, rsp_hs, r, pend;
    logic [31:0] addr, paddr;
    int          cnt;
    pend = 1'b0;
    paddr = 32'h0;
    cnt = 0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data = 32'h0;
    mem_rsp_err = 1'b0;
    forever begin
      @(negedge clk);
      req_hs = mem_req_valid && mem_req_ready;
      rsp_hs = mem_rsp_valid && mem_rsp_ready;
      addr = mem_req_addr;
      r = rst;
      @(posedge clk);
      #1;
      if (r) begin
        pend = 1'b0;
        mem_rsp_valid = 1'b0;
      end else begin
        if (rsp_hs) begin
          mem_rsp_valid = 1'b0;
          pend = 1'b0;
        end
        if (req_hs) begin
          pend = 1'b1;
          paddr = addr;
          cnt = rsp_delay;
        end
        if (pend && !mem_rsp_valid) begin
          if (cnt == 0) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data = {paddr[15:0], 16'h0013};
            mem_rsp_err = (paddr == err_addr);
          end else begin
            cnt--;
          end
        end
      end
    end
  end

  // Scoreboard monitor: every output handshake must match the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL sb_unexpected: got pc %h inst %h expected no output", out_pc, out_inst);
        end else begin
          e = sb.pop_front();
          chk("sb_pc", out_pc, e.pc);
          chk("sb_inst", out_inst, e.inst);
          chk("sb_fault", {31'd0, out_fault}, {31'd0, e.fault});
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    mem_req_ready = 1'b1;
    out_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;

    tick();
    chk("rst_req_valid", {31'd0, mem_req_valid}, 32'd0);
    chk("rst_rsp_ready", {31'd0, mem_rsp_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_count", fetch_count, 32'd0);
    chk("rst_inst", out_inst, 32'd0);
    chk("rst_fault", {31'd0, out_fault}, 32'd0);
    chk("rst_pc", out_pc, 32'h8000_0000);
    tick();
    rst = 1'b0;
    chk("boot_req_valid", {31'd0, mem_req_valid}, 32'd0);
    tick();
    chk("first_req_valid", {31'd0, mem_req_valid}, 32'd1);
    chk("first_req_addr", mem_req_addr, 32'h8000_0000);

    // Backpressure on the first instruction.
    expect_out(32'h8000_0000, 32'h0000_0013, 1'b0);
    wait_out("first");
    for (int i = 0; i < 5; i++) begin
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_out_pc", out_pc, 32'h8000_0000);
      chk("bp_out_inst", out_inst, 32'h0000_0013);
      chk("bp_req_valid", {31'd0, mem_req_valid}, 32'd0);
      chk("bp_count", fetch_count, 32'd0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_count_after", fetch_count, 32'd1);
    wait_req("seq", 32'h8000_0004);

    do_fetch("seq", 32'h8000_0004, 32'h0004_0013, 1'b0);
    err_addr = 32'h8000_0008;
    do_fetch("err", 32'h8000_0008, 32'h0008_0013, 1'b1);

    // Redirect while the slow response is still outstanding.
    rsp_delay = 3;
    wait_req("pre_redir", 32'h8000_000c);
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_0100;
    tick();
    redirect_valid = 1'b0;
    rsp_delay = 0;
    chk("drop_rsp_ready", {31'd0, mem_rsp_ready}, 32'd1);
    wait_req("redir_wait", 32'h8000_0100);
    do_fetch("redir_wait", 32'h8000_0100, 32'h0100_0013, 1'b0);

    // Redirect in the same cycle as the response.
    wait_req("pre_coinc", 32'h8000_0104);
    tick();
    chk("coinc_rsp_ready", {31'd0, mem_rsp_ready}, 32'd1);
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_0180;
    tick();
    redirect_valid = 1'b0;
    chk("coinc_req_valid", {31'd0, mem_req_valid}, 32'd1);
    chk("coinc_req_addr", mem_req_addr, 32'h8000_0180);
    do_fetch("coinc", 32'h8000_0180, 32'h0180_0013, 1'b0);

    // Misaligned redirect from REQ with memory stalled.
    mem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_0102;
    expect_out(32'h8000_0102, 32'h0, 1'b1);
    tick();
    redirect_valid = 1'b0;
    chk("mis_req_valid", {31'd0, mem_req_valid}, 32'd0);
    chk("mis_out_valid", {31'd0, out_valid}, 32'd1);
    chk("mis_out_pc", out_pc, 32'h8000_0102);
    chk("mis_out_inst", out_inst, 32'h0);
    chk("mis_out_fault", {31'd0, out_fault}, 32'd1);

    // Handshake and redirect at the same edge.
    mem_req_ready = 1'b1;
    out_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_0200;
    tick();
    out_ready = 1'b0;
    redirect_valid = 1'b0;
    chk("hs_redir_count", fetch_count, 32'd6);
    chk("hs_redir_req_valid", {31'd0, mem_req_valid}, 32'd1);
    chk("hs_redir_req_addr", mem_req_addr, 32'h8000_0200);
    do_fetch("hs_redir", 32'h8000_0200, 32'h0200_0013, 1'b0);
    chk("count_7", fetch_count, 32'd7);

    // Reset while a slow fetch is outstanding.
    rsp_delay = 3;
    wait_req("pre_rst", 32'h8000_0204);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rsp_delay = 0;
    chk("mid_rst_req_valid", {31'd0, mem_req_valid}, 32'd0);
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_count", fetch_count, 32'd0);
    chk("mid_rst_pc", out_pc, 32'h8000_0000);
    do_fetch("after_rst", 32'h8000_0000, 32'h0000_0013, 1'b0);
    chk("after_rst_count", fetch_count, 32'd1);

    for (int i = 0; i < 10; i++) tick();
    chk("sb_drained", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_22050612_ifu.md
Name: ysyx_22050612_ifu

Overview:
- Instruction fetch unit for the NPC core.
- Holds the PC, issues one 32-bit fetch at a time over a valid/ready memory channel, and presents {pc, inst, fault} to the decoder over a valid/ready output channel.
- The decoder's opcode-keyed selectors consume out_inst directly.
- Redirects (branch/jump/trap targets) from execute flush any in-flight fetch.

Parameters:
- RESET_PC, 32'h8000_0000, PC loaded on reset; must be 4-byte aligned.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous active-high reset
- mem_req_valid  out  1  fetch request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  32  fetch address (= pc)
- mem_rsp_valid  in  1  response valid
- mem_rsp_ready  out  1  IFU accepts response
- mem_rsp_data  in  32  fetched instruction word
- mem_rsp_err  in  1  access fault on this response
- out_valid  out  1  instruction available to decoder
- out_ready  in  1  decoder accepts instruction
- out_pc  out  32  PC of presented instruction
- out_inst  out  32  instruction word
- out_fault  out  1  fetch fault (access error or misaligned target)
- redirect_valid  in  1  execute requests PC change
- redirect_pc  in  32  new PC
- fetch_count  out  32  completed output handshakes, wraps at 2^32

Behaviour:
- **States:** BOOT, REQ, WAIT, DROP, HOLD; state is registered.
- **Output decode** (combinational from state only):
  - mem_req_valid = (state==REQ)
  - mem_req_addr = pc
  - mem_rsp_ready = (state==WAIT || state==DROP)
  - out_valid = (state==HOLD)
- **Reset** (rst high at an edge):
  - state=BOOT, pc=RESET_PC, out_inst=0, out_fault=0, fetch_count=0.
  - While in BOOT, all valid/ready outputs are 0.
- **BOOT:** next cycle go to REQ unconditionally. Redirect is ignored.
- **REQ:**
  - On mem_req_ready, go to WAIT.
  - With redirect_valid, pc<=redirect_pc and redirect has priority:
    - handshake in the same cycle: go to DROP;
    - no handshake: stay in REQ (re-request the new pc next cycle).
- **WAIT:**
  - On mem_rsp_valid, latch out_inst<=mem_rsp_data and out_fault<=mem_rsp_err, then go to HOLD.
  - With redirect_valid, pc<=redirect_pc and no latch occurs:
    - mem_rsp_valid in the same cycle: go to REQ (response consumed and discarded);
    - otherwise: go to DROP.
- **DROP:**
  - Discards exactly one response: on mem_rsp_valid, go to REQ.
  - With redirect_valid, pc<=redirect_pc and the state is unchanged, unless mem_rsp_valid is high (then go to REQ).
- **HOLD:**
  - out_pc=pc. out_inst and out_fault are stable while out_valid && !out_ready.
  - Handshake = out_valid && out_ready. It increments fetch_count.
  - Handshake without redirect: pc<=pc+4 (mod 2^32), go to REQ.
  - With redirect_valid (with or without handshake): pc<=redirect_pc, go to REQ. A same-cycle handshake still counts as transferred and still increments fetch_count.
- **Misaligned target:**
  - Applies when a pc loaded from redirect_pc has bits[1:0]≠0.
  - On the next entry to REQ, no memory request is issued. The IFU goes directly to HOLD with out_inst=0 and out_fault=1.
  - A misaligned pc in DROP takes effect when DROP exits.
- **Ordering and latency:**
  - Strictly one outstanding request; responses return in order.
  - Latency: request issued the cycle after entering REQ. out_valid asserts the cycle after the mem_rsp_valid handshake.
  - Zero-wait memory gives one instruction per 3 cycles (REQ, WAIT, HOLD).
- **Reset mid-operation:**
  - Aborts everything and returns to BOOT.
  - A late memory response to the aborted request must not be presented. Memory is reset by the same rst.

Test Plan:
- **Reset then fetch:** assert rst for 2 cycles, memory always ready, returns 0x00000013 in 1 cycle.
  - mem_req_valid=0 during reset and BOOT.
  - First request addr 0x80000000; out_valid with out_pc=0x80000000, out_inst=0x00000013.
  - After out_ready, next request addr 0x80000004.
- **Backpressure:** hold out_ready=0 for 5 cycles in HOLD.
  - out_valid stays 1; out_pc and out_inst stable; no new mem_req_valid; fetch_count unchanged until the handshake, then +1.
- **Redirect during WAIT:** response delayed 3 cycles; redirect_pc=0x80000100 the cycle after the request.
  - Stale response dropped (never on out_*); next request addr 0x80000100; out_pc=0x80000100.
- **Redirect coincident with response in WAIT:**
  - Goes straight to REQ; next addr = redirect_pc; exactly one response consumed.
- **Faults:**
  - mem_rsp_err=1 on fetch of 0x80000008: out_fault=1, out_pc=0x80000008.
  - redirect_pc=0x80000102: no memory request; out_fault=1, out_inst=0, out_pc=0x80000102.
- **Redirect with handshake in HOLD:**
  - out_ready=1 and redirect_pc=0x80000200 at the same edge: fetch_count +1; next addr 0x80000200, not pc+4.
